// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: turns the UART byte stream (header/value pairs) into ALU
// operand/opcode register writes, then hands the ALU result to the UART
// transmitter with a start/done handshake. Aborts a stalled pair on a
// baud-tick timeout and flags unknown header bytes.
module alu_uart_ctrl #(
  parameter int                 NB_DATA       = 8,
  parameter int                 NB_OP         = 6,
  parameter logic [NB_DATA-1:0] HDR_A         = NB_DATA'(8'h08),
  parameter logic [NB_DATA-1:0] HDR_B         = NB_DATA'(8'h10),
  parameter logic [NB_DATA-1:0] HDR_OP        = NB_DATA'(8'h20),
  parameter int                 TIMEOUT_TICKS = 4096
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  // The tick that brings the count to TIMEOUT_TICKS is the terminal one,
  // so the abort is decided while the counter still holds TIMEOUT_TICKS-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VAL = 2'd1,
    COMPUTE  = 2'd2,
    WAIT_TX  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2,
    SEL_OP   = 2'd3
  } sel_t;

  state_t             state, state_next;
  sel_t               sel, sel_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NB_DATA-1:0] data_a_next, data_b_next, tx_data_next;
  logic [NB_OP-1:0]   op_next;
  logic               tx_start_next, busy_next, err_next;

  // State, selector and timeout counter registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      sel   <= SEL_NONE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state decode plus next values for every registered output.
  always_comb begin
    state_next    = state;
    sel_next      = sel;
    cnt_next      = cnt;
    data_a_next   = o_data_a;
    data_b_next   = o_data_b;
    op_next       = o_op;
    tx_data_next  = o_tx_data;
    tx_start_next = 1'b0;
    err_next      = 1'b0;

    case (state)
      IDLE: begin
        if (i_rx_done) begin
          cnt_next = '0;
          if (i_rx_data == HDR_A) begin
            sel_next   = SEL_A;
            state_next = WAIT_VAL;
          end else if (i_rx_data == HDR_B) begin
            sel_next   = SEL_B;
            state_next = WAIT_VAL;
          end else if (i_rx_data == HDR_OP) begin
            sel_next   = SEL_OP;
            state_next = WAIT_VAL;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      WAIT_VAL: begin
        // A value byte wins over a coincident terminal tick.
        if (i_rx_done) begin
          sel_next   = SEL_NONE;
          state_next = IDLE;
          case (sel)
            SEL_A:   data_a_next = i_rx_data;
            SEL_B:   data_b_next = i_rx_data;
            SEL_OP: begin
              op_next    = i_rx_data[NB_OP-1:0];
              state_next = COMPUTE;
            end
            default: ;
          endcase
        end else if (i_tick) begin
          if (cnt == CNT_LAST) begin
            err_next   = 1'b1;
            sel_next   = SEL_NONE;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      // The new opcode has been on o_op for one cycle; the ALU has settled.
      COMPUTE: begin
        tx_data_next  = i_alu_result;
        tx_start_next = 1'b1;
        state_next    = WAIT_TX;
      end

      WAIT_TX: begin
        if (i_tx_done) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next == COMPUTE) || (state_next == WAIT_TX);
  end

  // Registered outputs; all clear on reset so the ALU and transmitter see zeros.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_data_a   <= data_a_next;
      o_data_b   <= data_b_next;
      o_op       <= op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= tx_start_next;
      o_busy     <= busy_next;
      o_err      <= err_next;
    end
  end

endmodule
